decompress_block: RTL and testbench

Inverse of the per-block compression path: accepts one 8x8 block of quantized DCT coefficients, dequantizes it, and runs a separable 2-D inverse DCT on a sequential engine to rebuild the signed Q9.0 pixel block. It is the building block that a decompressor top level instantiates per 8x8 tile, in the same way the compressor instantiates its block cores. It uses the same start/done handshake style as the compression cores.

---
 rtl/decompress_block.sv | 180 ++++++++++++++++++
 tb/tb_decompress_block.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/decompress_block.sv
`default_nettype none
// ============================================================================
// decompress_block : dequantize one 8x8 coefficient block and rebuild signed
//                    Q9.0 pixels with a sequential separable 2-D inverse DCT.
// Option macro     : DECOMPRESS_DEQUANT_EN (JPEG luminance dequantization)
// Revision         : 1.0
// ============================================================================
module decompress_block #(
  parameter int BLOCK_SIZE  = 8,
  parameter int COEFF_WIDTH = 12
) (
  input  logic                                                       clk,
  input  logic                                                       rst_n,
  input  logic                                                       start_block,
  input  logic signed [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][COEFF_WIDTH-1:0] coeffs,
  output logic signed [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][8:0]          pixels_out,
  output logic                                                       block_done
);

  localparam int XW = COEFF_WIDTH + 8;   // dequantized coefficient
  localparam int TW = COEFF_WIDTH + 12;  // row-pass intermediate
  localparam int PW = TW + 9;            // one basis product
  localparam int SW = PW + 3;            // sum of eight products

`ifdef DECOMPRESS_DEQUANT_EN
  localparam logic [0:63][7:0] Q_ROM = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROW_PASS = 2'd1,
    COL_PASS = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state, state_next;
  logic [5:0] idx;
  logic [2:0] row, col;
  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][XW-1:0] deq;
  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][XW-1:0] x_mem;
  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][TW-1:0] t_mem;

  logic signed [TW-1:0] op_a [BLOCK_SIZE];
  logic signed [8:0]    op_c [BLOCK_SIZE];
  logic signed [PW-1:0] prod [BLOCK_SIZE];
  logic signed [SW-1:0] lvl1 [4];
  logic signed [SW-1:0] lvl2 [2];
  logic signed [SW-1:0] acc;
  logic signed [SW-1:0] rnd;
  logic signed [8:0]    sat;

  assign row = idx[5:3];
  assign col = idx[2:0];

  // Q1.8 basis C[k][n]; the cosine argument (2k+1)n*pi/16 is folded mod 2*pi
  // onto a 0..pi/2 magnitude table plus a sign.
  function automatic logic signed [8:0] idct_coef(input logic [2:0] k, input logic [2:0] n);
    logic [4:0] m;
    logic [3:0] j;
    logic [7:0] mag;
    logic       neg;
    m   = {1'b0, k, 1'b1} * {2'b00, n};
    j   = m[3:0];
    neg = m[4];
    if (j > 4'd8) begin
      j   = 4'd0 - j;
      neg = ~neg;
    end
    case (j)
      4'd0:    mag = 8'd128;
      4'd1:    mag = 8'd126;
      4'd2:    mag = 8'd118;
      4'd3:    mag = 8'd106;
      4'd4:    mag = 8'd91;
      4'd5:    mag = 8'd71;
      4'd6:    mag = 8'd49;
      4'd7:    mag = 8'd25;
      default: mag = 8'd0;
    endcase
    if (n == 3'd0)
      return 9'sd91;
    else if (neg)
      return -$signed({1'b0, mag});
    else
      return $signed({1'b0, mag});
  endfunction

  always_comb begin
    deq = '0;
    for (int u = 0; u < BLOCK_SIZE; u++) begin
      for (int v = 0; v < BLOCK_SIZE; v++) begin
`ifdef DECOMPRESS_DEQUANT_EN
        deq[u][v] = XW'($signed(coeffs[u][v])) * XW'($signed({1'b0, Q_ROM[u*BLOCK_SIZE+v]}));
`else
        deq[u][v] = XW'($signed(coeffs[u][v]));
`endif
      end
    end
  end

  // Both passes share the eight multipliers and the adder tree.
  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (state == ROW_PASS) begin
        op_a[i] = TW'($signed(x_mem[i][col]));
        op_c[i] = idct_coef(row, 3'(i));
      end else begin
        op_a[i] = $signed(t_mem[row][i]);
        op_c[i] = idct_coef(col, 3'(i));
      end
      prod[i] = PW'(op_a[i]) * PW'(op_c[i]);
    end
    for (int i = 0; i < 4; i++)
      lvl1[i] = SW'(prod[2*i]) + SW'(prod[2*i+1]);
    lvl2[0] = lvl1[0] + lvl1[1];
    lvl2[1] = lvl1[2] + lvl1[3];
    acc     = lvl2[0] + lvl2[1];
    rnd     = (acc + SW'(128)) >>> 8;
    if (rnd > SW'(255))
      sat = 9'h0FF;
    else if (rnd < SW'(-256))
      sat = 9'h100;
    else
      sat = rnd[8:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_block) state_next = ROW_PASS;
      ROW_PASS: if (idx == 6'd63) state_next = COL_PASS;
      COL_PASS: if (idx == 6'd63) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      block_done <= 1'b0;
      pixels_out <= '0;
      x_mem      <= '0;
      t_mem      <= '0;
    end else begin
      state      <= state_next;
      block_done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start_block) begin
            x_mem <= deq;
            idx   <= '0;
          end
        end
        ROW_PASS: begin
          // idx wraps 63 -> 0 on entry to the column pass.
          t_mem[row][col] <= rnd[TW-1:0];
          idx             <= idx + 6'd1;
        end
        COL_PASS: begin
          pixels_out[row][col] <= sat;
          idx                  <= idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decompress_block.sv
`default_nettype none
// tb_decompress_block: directed vectors with a scoreboard queue and a
// negedge monitor that checks every block_done pulse (pixels and timing).
module tb_decompress_block;

  logic                    clk;
  logic                    rst_n;
  logic                    start_block;
  logic [7:0][7:0][11:0]   coeffs;
  logic [7:0][7:0][8:0]    pixels_out;
  logic                    block_done;

  decompress_block #(.BLOCK_SIZE(8), .COEFF_WIDTH(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_block (start_block),
    .coeffs      (coeffs),
    .pixels_out  (pixels_out),
    .block_done  (block_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0][8:0] pix;
    logic [31:0]      due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

`ifdef DECOMPRESS_DEQUANT_EN
  localparam int DC_IN   = 8;
  localparam int AC01_IN = 23;
  localparam int AC10_IN = 21;
  localparam int AC02_IN = 25;
  int ac1_pat[8] = '{44, 37, 25, 9, -9, -25, -37, -44};
  int ac2_pat[8] = '{41, 17, -17, -41, -41, -17, 17, 41};
`else
  localparam int DC_IN   = 128;
  localparam int AC01_IN = 256;
  localparam int AC10_IN = 256;
  localparam int AC02_IN = 256;
  int ac1_pat[8] = '{45, 38, 25, 9, -9, -25, -38, -45};
  int ac2_pat[8] = '{42, 17, -17, -42, -42, -17, 17, 42};
`endif

  function automatic logic [63:0][8:0] exp_fill(input int val);
    logic [63:0][8:0] p;
    for (int i = 0; i < 64; i++) p[i] = 9'(val);
    return p;
  endfunction

  function automatic logic [63:0][8:0] exp_by_col(input int pat[8]);
    logic [63:0][8:0] p;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) p[x*8+y] = 9'(pat[y]);
    return p;
  endfunction

  function automatic logic [63:0][8:0] exp_by_row(input int pat[8]);
    logic [63:0][8:0] p;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) p[x*8+y] = 9'(pat[x]);
    return p;
  endfunction

  function automatic logic [7:0][7:0][11:0] one_coeff(input int u, input int v, input int val);
    logic [7:0][7:0][11:0] c;
    c = '0;
    c[u][v] = 12'(val);
    return c;
  endfunction

  always @(negedge clk) begin
    if (rst_n && block_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done cyc=%0d actual=1 required=0", cyc);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (cyc != int'(mon_e.due)) begin
          errors++;
          $display("FAIL done_edge actual=%0d required=%0d", cyc, mon_e.due);
        end
        for (int x = 0; x < 8; x++) begin
          for (int y = 0; y < 8; y++) begin
            checks++;
            if (pixels_out[x][y] !== mon_e.pix[x*8+y]) begin
              errors++;
              $display("FAIL pix[%0d][%0d] actual=%0d required=%0d", x, y,
                       $signed(pixels_out[x][y]), $signed(mon_e.pix[x*8+y]));
            end
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Start edge N = next posedge; done is seen after edge N+128.
  task automatic issue(input logic [7:0][7:0][11:0] c, input logic [63:0][8:0] pix);
    exp_t e;
    wait_idle();
    coeffs      = c;
    start_block = 1'b1;
    e.pix = pix;
    e.due = 32'(cyc + 1 + 128);
    sb.push_back(e);
    @(negedge clk);
    start_block = 1'b0;
  endtask

  initial begin
    exp_t e;
    int n0;
    rst_n       = 1'b0;
    start_block = 1'b0;
    coeffs      = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (pixels_out !== '0) begin
      errors++;
      $display("FAIL reset_pixels actual=%h required=0", pixels_out);
    end
    checks++;
    if (block_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done actual=%b required=0", block_done);
    end
    rst_n = 1'b1;
    @(negedge clk);

    issue('0, exp_fill(0));
    issue(one_coeff(0, 0, DC_IN), exp_fill(16));
    issue(one_coeff(0, 1, AC01_IN), exp_by_col(ac1_pat));
    issue(one_coeff(1, 0, AC10_IN), exp_by_row(ac1_pat));
    issue(one_coeff(0, 2, AC02_IN), exp_by_col(ac2_pat));
    issue(one_coeff(0, 0, 2047), exp_fill(255));
    issue(one_coeff(0, 0, -2048), exp_fill(-256));

    // Back-to-back with start held high; coeffs change mid-decode.
    wait_idle();
    coeffs      = one_coeff(0, 0, DC_IN);
    start_block = 1'b1;
    n0 = cyc + 1;
    e.pix = exp_fill(16);
    e.due = 32'(n0 + 128);
    sb.push_back(e);
    e.pix = exp_by_col(ac1_pat);
    e.due = 32'(n0 + 130 + 128);
    sb.push_back(e);
    repeat (20) @(negedge clk);
    coeffs = one_coeff(0, 1, AC01_IN);
    while (cyc < n0 + 130) @(negedge clk);
    start_block = 1'b0;

    // Abort a decode with reset at cycle 70.
    wait_idle();
    coeffs      = one_coeff(1, 0, AC10_IN);
    start_block = 1'b1;
    @(negedge clk);
    start_block = 1'b0;
    repeat (69) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pixels_out !== '0) begin
      errors++;
      $display("FAIL abort_pixels actual=%h required=0", pixels_out);
    end
    checks++;
    if (block_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_done actual=%b required=0", block_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(one_coeff(1, 0, AC10_IN), exp_by_row(ac1_pat));

    wait_idle();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
